seq_mult: RTL and testbench
===========================

Name: seq_mult

Overview:
- Parametrised sequential shift-add multiplier; successor to the fixed 16-bit load-triggered multiplier.
- Adds a selectable signed/unsigned mode and a valid/ready handshake on both input and output.
- Fixed latency of one partial-product bit per cycle; result is held until consumed.
- Sits beside the ALU as a multi-cycle arithmetic unit; the ALU or datapath issues operands and collects the product.

Parameters:
- WIDTH, 16, operand width in bits (>=2); product is 2*WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- res_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and mode valid
- in_ready  out  1  block can accept operands
- x  in  WIDTH  multiplicand
- y  in  WIDTH  multiplier
- sgn  in  1  1 = two's-complement operands, 0 = unsigned
- p  out  2*WIDTH  product, registered
- out_valid  out  1  p holds a completed product
- out_ready  in  1  consumer takes p

Behaviour:
- Clocking and reset: one clock, clk; reset res_n is asynchronous, active-low.
- Reset: state=IDLE; p=0; out_valid=0; counter=0; internal operand and accumulator registers=0. in_ready=1 once res_n deasserts.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - Accept edge: in_valid=1 on a rising clk edge.
    - At the accept edge, capture mx=|x| and my=|y| (magnitude only when sgn=1 and the MSB is set, else raw).
    - At the accept edge, capture neg = sgn & (x[W-1]^y[W-1]), acc=0, cnt=WIDTH. Go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - If the LSB of the shift register is 1, add mx into the upper half (WIDTH+1-bit adder to hold the carry).
    - Shift the {carry,acc,my} pair right by 1; cnt decrements.
    - On the cycle where cnt reaches 0, load p with the finished magnitude, two's-complement negated if neg. Go to DONE.
  - DONE: out_valid=1, p stable, in_ready=0.
    - out_ready=1 at an edge returns to IDLE; out_valid falls and p keeps its value.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge, regardless of operand values (zero operands are not shortcut).
- Throughput: at most one operation per WIDTH+2 cycles. There is no accept in the same cycle as the DONE->IDLE handoff, because in_ready is registered-state-decoded.
- in_valid while in_ready=0 is ignored; operands are not latched. x, y and sgn may change freely after the accept edge.
- Width and sign rules:
  - Magnitude of -2^(W-1) is 2^(W-1), which fits W bits unsigned.
  - Signed min*min = 2^(2W-2) is positive and representable.
  - The unsigned result is the full 2W-bit product; there is no truncation or overflow flag.
- Reset mid-operation: res_n low at any time aborts immediately to reset values. The next accepted operation is fully correct.
- Simultaneous events: out_ready is don't-care outside DONE. in_valid and out_ready both high in DONE means pop only; the new operand is not taken.

Decomposition:
- Package seq_mult_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - function clog2 for cnt width: $clog2(WIDTH+1)
- Sub-module cond_negate #(N): output = en ? -in : in.
  - Instantiated twice at WIDTH for operand magnitudes.
  - Instantiated once at 2*WIDTH for the result sign fix.
- Everything else (FSM, counter, shift/add datapath, output register) lives in seq_mult.

Test Plan:
- WIDTH=16, sgn=0, x=0xFFFF, y=0xFFFF -> p=0xFFFE0001, out_valid exactly 16 cycles after the accept edge, in_ready=0 throughout.
- WIDTH=16, sgn=1, x=0xFFFD (-3), y=0x0005 -> p=0xFFFFFFF1. Then sgn=1, x=0x8000, y=0x0001 -> p=0xFFFF8000.
- WIDTH=16, x=0x8000, y=0x8000 with sgn=1 -> p=0x40000000; with sgn=0 -> p=0x40000000. Also x=0, y=0x1234 -> p=0 with the full 16-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> p and out_valid stable, in_ready=0, no new accept. Raise out_ready -> IDLE next edge, in_ready=1.
- Reset mid-run: assert res_n=0 at RUN cycle 7 of 3*7 -> p=0, out_valid=0 asynchronously. Release, issue 3*7 unsigned -> p=0x00000015 after 16 cycles.
- WIDTH=8 instance: sgn=1, x=0x80, y=0x7F -> p=0xC080 after 8 cycles. sgn=0 on the same operands -> p=0x3F80.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state encoding and sizing helper for the sequential multiplier
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int clog2(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/seq_mult_if.sv
// seq_mult_if: operand/result handshake bundle between the issuing datapath and the multiplier
interface seq_mult_if #(parameter int WIDTH = 16);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic sgn;
  logic [2*WIDTH-1:0] p;
  logic out_valid;
  logic out_ready;
  modport master (output in_valid, x, y, sgn, out_ready, input in_ready, p, out_valid);
  modport slave (input in_valid, x, y, sgn, out_ready, output in_ready, p, out_valid);
endinterface

// File: rtl/seq_mult_cond_negate.sv
// cond_negate: two's-complement negation of i_in when i_en is set, pass-through otherwise
module cond_negate #(parameter int N = 16) (
  input  logic         i_en,
  input  logic [N-1:0] i_in,
  output logic [N-1:0] o_out
);
  assign o_out = i_en ? -i_in : i_in;
endmodule

// File: rtl/seq_mult.sv
// seq_mult: shift-add multiplier, one partial-product bit per cycle, signed or unsigned operands
module seq_mult import seq_mult_pkg::*; #(parameter int WIDTH = 16) (
  input logic clk,
  input logic res_n,
  seq_mult_if.slave bus
);
  localparam int CW = clog2(WIDTH + 1);
  state_t r_state;
  logic r_in_ready;
  logic r_out_valid;
  logic r_neg;
  logic [WIDTH-1:0] r_mx;
  logic [WIDTH-1:0] r_my;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0] w_mx;
  logic [WIDTH-1:0] w_my;
  logic [WIDTH:0] w_sum;
  logic [2*WIDTH-1:0] w_mag;
  logic [2*WIDTH-1:0] w_res;
  cond_negate #(.N(WIDTH)) u_neg_x (.i_en(bus.sgn & bus.x[WIDTH-1]), .i_in(bus.x), .o_out(w_mx));
  cond_negate #(.N(WIDTH)) u_neg_y (.i_en(bus.sgn & bus.y[WIDTH-1]), .i_in(bus.y), .o_out(w_my));
  assign w_sum = {1'b0, r_acc} + (r_my[0] ? {1'b0, r_mx} : '0);
  assign w_mag = {w_sum, r_my[WIDTH-1:1]};
  cond_negate #(.N(2*WIDTH)) u_neg_p (.i_en(r_neg), .i_in(w_mag), .o_out(w_res));
  assign bus.in_ready = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.p = r_p;
  // control FSM plus shift/add datapath; the shifted {carry,acc,my} pair is the running product
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= IDLE;
      r_in_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_neg <= 1'b0;
      r_mx <= '0;
      r_my <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_p <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_mx <= w_mx;
          r_my <= w_my;
          r_neg <= bus.sgn & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
          r_acc <= '0;
          r_cnt <= CW'(WIDTH);
          r_in_ready <= 1'b0;
          r_state <= RUN;
        end
        RUN: begin
          r_acc <= w_sum[WIDTH:1];
          r_my <= w_mag[WIDTH-1:0];
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_p <= w_res;
            r_out_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed vectors with a scoreboard queue and an independent result monitor
module tb_seq_mult;
  logic clk = 1'b0;
  logic res_n = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {logic [31:0] p; int acc;} exp_t;
  exp_t q16[$];
  exp_t q8[$];
  logic pv16 = 1'b0;
  logic pv8 = 1'b0;

  seq_mult_if #(.WIDTH(16)) b16();
  seq_mult_if #(.WIDTH(8)) b8();
  seq_mult #(.WIDTH(16)) u16 (.clk(clk), .res_n(res_n), .bus(b16.slave));
  seq_mult #(.WIDTH(8)) u8 (.clk(clk), .res_n(res_n), .bus(b8.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // monitor: each rising out_valid pops one expected product and checks value and latency
  always @(negedge clk) begin : mon
    exp_t e;
    if (b16.out_valid && !pv16) begin
      if (q16.size() == 0) check("m16_unexpected", 1, 0);
      else begin
        e = q16.pop_front();
        check("m16_p", b16.p, e.p);
        check("m16_latency", cyc - e.acc, 16);
      end
    end
    if (b8.out_valid && !pv8) begin
      if (q8.size() == 0) check("m8_unexpected", 1, 0);
      else begin
        e = q8.pop_front();
        check("m8_p", b8.p, e.p);
        check("m8_latency", cyc - e.acc, 8);
      end
    end
    pv16 = b16.out_valid;
    pv8 = b8.out_valid;
  end

  task automatic op16(input logic s, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] e, input string nm, input int hold);
    int k;
    bit ok;
    k = 0;
    while (!b16.in_ready && k < 50) begin @(negedge clk); k++; end
    check({nm, "_rdy"}, b16.in_ready, 1);
    b16.in_valid = 1'b1; b16.sgn = s; b16.x = a; b16.y = b; b16.out_ready = 1'b0;
    @(posedge clk); #1;
    q16.push_back('{p: e, acc: cyc});
    b16.in_valid = 1'b0; b16.sgn = ~s; b16.x = ~a; b16.y = ~b;
    ok = 1'b1;
    k = 0;
    while (!b16.out_valid && k < 40) begin
      @(negedge clk);
      if (b16.in_ready) ok = 1'b0;
      k++;
    end
    check({nm, "_busy"}, ok, 1);
    check({nm, "_done"}, b16.out_valid, 1);
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      b16.in_valid = i[0] ? 1'b0 : 1'b1; b16.x = 16'h0003; b16.y = 16'h0003;
      @(negedge clk);
      if (!b16.out_valid || b16.in_ready || b16.p !== e) ok = 1'b0;
    end
    if (hold > 0) begin
      check({nm, "_hold"}, ok, 1);
      b16.in_valid = 1'b1;
    end
    b16.out_ready = 1'b1;
    @(posedge clk); #1;
    b16.out_ready = 1'b0; b16.in_valid = 1'b0;
    check({nm, "_pop"}, {b16.out_valid, b16.in_ready}, 2'b01);
    check({nm, "_keep"}, b16.p, e);
    if (hold > 0) begin
      @(negedge clk);
      check({nm, "_noaccept"}, b16.in_ready, 1);
    end
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] e, input string nm);
    int k;
    b8.in_valid = 1'b1; b8.sgn = s; b8.x = a; b8.y = b; b8.out_ready = 1'b0;
    @(posedge clk); #1;
    q8.push_back('{p: {16'h0, e}, acc: cyc});
    b8.in_valid = 1'b0; b8.x = ~a; b8.y = ~b;
    k = 0;
    while (!b8.out_valid && k < 30) begin @(negedge clk); k++; end
    check({nm, "_done"}, b8.out_valid, 1);
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    check({nm, "_pop"}, {b8.out_valid, b8.in_ready}, 2'b01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    b16.in_valid = 1'b0; b16.x = '0; b16.y = '0; b16.sgn = 1'b0; b16.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.x = '0; b8.y = '0; b8.sgn = 1'b0; b8.out_ready = 1'b0;
    #12;
    check("rst_p16", b16.p, 0);
    check("rst_ov16", b16.out_valid, 0);
    check("rst_p8", b8.p, 0);
    @(negedge clk); res_n = 1'b1;
    @(negedge clk);
    check("rst_rdy16", b16.in_ready, 1);
    op16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "u_max", 0);
    op16(1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, "s_m3x5", 0);
    op16(1'b1, 16'h8000, 16'h0001, 32'hFFFF8000, "s_minx1", 0);
    op16(1'b1, 16'h8000, 16'h8000, 32'h40000000, "s_minmin", 0);
    op16(1'b0, 16'h8000, 16'h8000, 32'h40000000, "u_8000sq", 0);
    op16(1'b0, 16'h0000, 16'h1234, 32'h00000000, "zero", 0);
    op16(1'b0, 16'h1234, 16'h0002, 32'h00002468, "bp", 5);
    op8(1'b1, 8'h80, 8'h7F, 16'hC080, "w8_s");
    op8(1'b0, 8'h80, 8'h7F, 16'h3F80, "w8_u");
    b16.in_valid = 1'b1; b16.sgn = 1'b0; b16.x = 16'd3; b16.y = 16'd7;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 res_n = 1'b0;
    #1;
    check("abort_p", b16.p, 0);
    check("abort_ov", b16.out_valid, 0);
    check("abort_rdy", b16.in_ready, 1);
    @(negedge clk); res_n = 1'b1;
    @(negedge clk);
    op16(1'b0, 16'd3, 16'd7, 32'h00000015, "after_rst", 0);
    repeat (3) @(negedge clk);
    check("q_empty", q16.size() + q8.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
